ahb_sram_slave_ws: RTL and testbench

Parametrised AHB-Lite SRAM slave, successor to the fixed 32-bit zero-wait RAM port. Adds:
- configurable data width, depth, base address and wait states;
- byte, halfword and word (and doubleword) write strobing derived from hsize/haddr;
- two-cycle ERROR responses for out-of-range, misaligned or oversize accesses;
- write-to-read forwarding across back-to-back transfers.
Sits behind the fanout/arbiter as a terminal slave on the port bus.

---
 rtl/ahb_sram_slave_ws.sv | 157 +++++++++++++++
 tb/tb_ahb_sram_slave_ws.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_ws.sv
// AHB-Lite SRAM slave with parametrised width, depth, base address and wait states.
// Byte-strobed writes, two-cycle ERROR responses and write-to-read forwarding.
module ahb_sram_slave_ws #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int BASE        = 0,
  parameter int WAIT_STATES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] P_BASE = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   P_SPAN = (ADDR_W + 1)'(DEPTH * NB);
  localparam logic [2:0]        P_WS   = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_cnt;
  logic [IDX_W-1:0]    r_word;
  logic [NB-1:0]       r_strb;
  logic                r_write, r_legal;
  logic [DATA_W-1:0]   r_hrdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   w_off;
  logic                w_accept, w_legal, w_in_range, w_size_ok, w_aligned;
  logic [LANE_W-1:0]   w_amask;
  logic [7:0]          w_ones;
  logic [NB-1:0]       w_strb;
  logic [IDX_W-1:0]    w_word, w_ld_word;
  logic                w_ld_write, w_ld_legal, w_load, w_commit;
  logic [DATA_W-1:0]   w_rd;
  logic                w_unused;

  assign w_unused = htrans[0];
  assign w_accept = hsel & hready & htrans[1] & hreadyout;

  // BASE is word aligned, so the low offset bits are the byte lane.
  assign w_off      = haddr - P_BASE;
  assign w_in_range = (haddr >= P_BASE) && ({1'b0, w_off} < P_SPAN);
  assign w_size_ok  = (hsize <= 3'(LANE_W));
  assign w_amask    = LANE_W'((8'd1 << hsize) - 8'd1);
  assign w_aligned  = (w_off[LANE_W-1:0] & w_amask) == '0;
  assign w_legal    = w_in_range & w_size_ok & w_aligned;
  assign w_word     = w_off[LANE_W +: IDX_W];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ones = 8'h00;
    case (hsize)
      3'd0:    w_ones = 8'h01;
      3'd1:    w_ones = 8'h03;
      3'd2:    w_ones = 8'h0F;
      3'd3:    w_ones = 8'hFF;
      default: w_ones = 8'h00;
    endcase
  end
  assign w_strb = NB'(w_ones) << w_off[LANE_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (!w_accept)                 w_next = S_IDLE;
        else if (!w_legal && ERR_EN != 0) w_next = S_ERR1;
        else if (WAIT_STATES == 0)     w_next = S_DONE;
        else                           w_next = S_WAIT;
      end
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_DONE;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (r_state)
      S_WAIT:  hreadyout = 1'b0;
      S_ERR1:  begin hreadyout = 1'b0; hresp = 1'b1; end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_strb  <= '0;
      r_write <= 1'b0;
      r_legal <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= P_WS;
      r_word  <= w_word;
      r_strb  <= w_strb;
      r_write <= hwrite;
      r_legal <= w_legal;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 3'd1;
    end
  end

  // With zero waits the read loads on its own accept edge, so use the live address.
  assign w_ld_word  = w_accept ? w_word  : r_word;
  assign w_ld_write = w_accept ? hwrite  : r_write;
  assign w_ld_legal = w_accept ? w_legal : r_legal;
  assign w_load     = (w_next == S_DONE) && !w_ld_write;
  assign w_commit   = (r_state == S_DONE) && r_write && r_legal;

  always_comb begin
    w_rd = mem[w_ld_word];
    if (w_commit && (r_word == w_ld_word)) begin
      for (int i = 0; i < NB; i++)
        if (r_strb[i]) w_rd[8*i +: 8] = hwdata[8*i +: 8];
    end
    if (!w_ld_legal) w_rd = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_hrdata <= '0;
    else if (w_load) r_hrdata <= w_rd;
  end
  assign hrdata = r_hrdata;

  // NOTE: the array has no reset so it maps onto plain RAM; aborted writes are blocked via r_state.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < NB; i++)
        if (r_strb[i]) mem[r_word][8*i +: 8] <= hwdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave_ws.sv
// Directed bench for ahb_sram_slave_ws: zero-wait 32-bit, 3-wait 32-bit and 64-bit instances
// share one address bus and are selected one at a time through hsel.
module tb_ahb_sram_slave_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel_v;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [29:0] haddr;
  logic [63:0] hwdata;
  logic        rdy0, rdy1, rdy2, rsp0, rsp1, rsp2;
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  int          n_vec = 0;
  int          n_miss = 0;
  int          n_wait;

  always #5 clk = ~clk;

  ahb_sram_slave_ws #(.ADDR_W(30), .DATA_W(32), .DEPTH(16), .BASE('h100),
                      .WAIT_STATES(0), .ERR_EN(1)) u_ws0 (
    .clock(clk), .reset(rst), .hsel(hsel_v[0]), .hready(rdy0), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata[31:0]),
    .hreadyout(rdy0), .hresp(rsp0), .hrdata(rd0));

  ahb_sram_slave_ws #(.ADDR_W(30), .DATA_W(32), .DEPTH(16), .BASE('h100),
                      .WAIT_STATES(3), .ERR_EN(1)) u_ws3 (
    .clock(clk), .reset(rst), .hsel(hsel_v[1]), .hready(rdy1), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata[31:0]),
    .hreadyout(rdy1), .hresp(rsp1), .hrdata(rd1));

  ahb_sram_slave_ws #(.ADDR_W(30), .DATA_W(64), .DEPTH(16), .BASE('h200),
                      .WAIT_STATES(0), .ERR_EN(1)) u_d64 (
    .clock(clk), .reset(rst), .hsel(hsel_v[2]), .hready(rdy2), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(rdy2), .hresp(rsp2), .hrdata(rd2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input int d, input logic w, input logic [2:0] sz, input logic [29:0] a);
    hsel_v = 3'b001 << d;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic bus_idle();
    hsel_v = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = '0;
  endtask

  // Counts hreadyout-low cycles on the 3-wait instance, giving up after 10.
  task automatic wait_ready1(output int n);
    n = 0;
    while (rdy1 == 1'b0 && n < 10) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst    = 1'b1;
    hwdata = '0;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset hreadyout ws0", rdy0, 1'b1);
    check("reset hresp ws0", rsp0, 1'b0);
    check("reset hrdata ws0", rd0, 32'h0);
    check("reset hreadyout d64", rdy2, 1'b1);
    check("reset hrdata d64", rd2, 64'h0);

    // Word write then back-to-back read of the same word.
    addr_ph(0, 1'b1, 3'd2, 30'h100);
    tick();
    hwdata = 64'hDEADBEEF;
    addr_ph(0, 1'b0, 3'd2, 30'h100);
    check("write data phase ready", rdy0, 1'b1);
    tick();
    bus_idle();
    check("b2b read ready", rdy0, 1'b1);
    check("b2b read hresp", rsp0, 1'b0);
    check("b2b read data", rd0, 32'hDEADBEEF);
    tick();

    // Word, byte, read all back-to-back: byte lane 1 forwarded into the read.
    addr_ph(0, 1'b1, 3'd2, 30'h104);
    tick();
    hwdata = 64'h11223344;
    addr_ph(0, 1'b1, 3'd0, 30'h105);
    tick();
    hwdata = 64'hAAAAAAAA;
    addr_ph(0, 1'b0, 3'd2, 30'h104);
    tick();
    bus_idle();
    check("byte forward read", rd0, 32'h1122AA44);
    tick();

    // Halfword at lane 2, then isolated reads straight from memory.
    addr_ph(0, 1'b1, 3'd1, 30'h106);
    tick();
    hwdata = 64'h55665566;
    bus_idle();
    tick();
    addr_ph(0, 1'b0, 3'd2, 30'h100);
    tick();
    bus_idle();
    check("mem read word0", rd0, 32'hDEADBEEF);
    tick();
    addr_ph(0, 1'b0, 3'd2, 30'h104);
    tick();
    bus_idle();
    check("halfword merged read", rd0, 32'h5566AA44);
    tick();

    // Out-of-range read: two-cycle ERROR, hrdata holds.
    addr_ph(0, 1'b0, 3'd2, 30'h140);
    tick();
    bus_idle();
    check("oor err1 ready", rdy0, 1'b0);
    check("oor err1 hresp", rsp0, 1'b1);
    check("oor hrdata hold", rd0, 32'h5566AA44);
    tick();
    check("oor err2 ready", rdy0, 1'b1);
    check("oor err2 hresp", rsp0, 1'b1);
    tick();
    check("after err ready", rdy0, 1'b1);
    check("after err hresp", rsp0, 1'b0);

    // Misaligned halfword write must not touch memory.
    addr_ph(0, 1'b1, 3'd1, 30'h101);
    tick();
    hwdata = 64'hFFFFFFFF;
    bus_idle();
    check("misaligned err1 hresp", rsp0, 1'b1);
    check("misaligned err1 ready", rdy0, 1'b0);
    tick();
    check("misaligned err2 ready", rdy0, 1'b1);
    tick();
    addr_ph(0, 1'b0, 3'd2, 30'h100);
    tick();
    bus_idle();
    check("word0 unchanged", rd0, 32'hDEADBEEF);
    tick();

    // Oversize on 32-bit and below-base address.
    addr_ph(0, 1'b0, 3'd3, 30'h108);
    tick();
    bus_idle();
    check("oversize hresp", rsp0, 1'b1);
    tick();
    tick();
    addr_ph(0, 1'b0, 3'd2, 30'h0FC);
    tick();
    bus_idle();
    check("below base hresp", rsp0, 1'b1);
    tick();
    tick();

    // Last legal word of the window.
    addr_ph(0, 1'b1, 3'd2, 30'h13C);
    tick();
    hwdata = 64'hCAFEF00D;
    bus_idle();
    tick();
    addr_ph(0, 1'b0, 3'd2, 30'h13C);
    tick();
    bus_idle();
    check("last word hresp", rsp0, 1'b0);
    check("last word data", rd0, 32'hCAFEF00D);
    tick();

    // Three wait states on write and read.
    addr_ph(1, 1'b1, 3'd2, 30'h108);
    tick();
    hwdata = 64'h12345678;
    bus_idle();
    wait_ready1(n_wait);
    check("ws3 write waits", 64'(n_wait), 64'd3);
    tick();
    addr_ph(1, 1'b0, 3'd2, 30'h108);
    tick();
    bus_idle();
    check("ws3 hrdata during wait", rd1, 32'h0);
    wait_ready1(n_wait);
    check("ws3 read waits", 64'(n_wait), 64'd3);
    check("ws3 read hresp", rsp1, 1'b0);
    check("ws3 read data", rd1, 32'h12345678);
    hsel_v = 3'b010;
    htrans = 2'b00;
    tick();
    check("ws3 idle xfer ready", rdy1, 1'b1);
    check("ws3 idle xfer hresp", rsp1, 1'b0);
    tick();

    // Reset during the wait of a write: ready returns at once, write dropped.
    addr_ph(1, 1'b1, 3'd2, 30'h108);
    tick();
    hwdata = 64'h0BADF00D;
    bus_idle();
    check("ws3 in wait", rdy1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset ready", rdy1, 1'b1);
    tick();
    rst = 1'b0;
    check("reset clears hrdata", rd1, 32'h0);
    tick();
    addr_ph(1, 1'b0, 3'd2, 30'h108);
    tick();
    bus_idle();
    wait_ready1(n_wait);
    check("aborted write waits", 64'(n_wait), 64'd3);
    check("aborted write dropped", rd1, 32'h12345678);
    tick();

    // 64-bit: doubleword, then word into upper lanes, forwarded then from memory.
    addr_ph(2, 1'b1, 3'd3, 30'h208);
    tick();
    hwdata = 64'h0123456789ABCDEF;
    addr_ph(2, 1'b1, 3'd2, 30'h20C);
    tick();
    hwdata = 64'hFFFFFFFFFFFFFFFF;
    addr_ph(2, 1'b0, 3'd3, 30'h208);
    tick();
    bus_idle();
    check("d64 forward read", rd2, 64'hFFFFFFFF89ABCDEF);
    tick();
    addr_ph(2, 1'b0, 3'd3, 30'h208);
    tick();
    bus_idle();
    check("d64 mem read", rd2, 64'hFFFFFFFF89ABCDEF);
    tick();
    addr_ph(2, 1'b0, 3'd3, 30'h20C);
    tick();
    bus_idle();
    check("d64 misaligned hresp", rsp2, 1'b1);
    check("d64 misaligned ready", rdy2, 1'b0);
    check("d64 err hrdata hold", rd2, 64'hFFFFFFFF89ABCDEF);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
